// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the completion queue slice:
//   ADDRW_DEFAULT - default completion address width (matches the SPI serializer)
//   state_t       - 2-bit handshake FSM encoding (ST_IDLE / ST_OFFER / ST_INFLIGHT)
//   clog2()       - constant-evaluable ceiling log2 used to size pointers and counters
package ctrl_pkg;

  localparam int ADDRW_DEFAULT = 32'sd24;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_OFFER    = 2'd1;
  localparam state_t ST_INFLIGHT = 2'd2;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/compl_fifo_mem.sv
// compl_fifo_mem
// Circular storage for completion addresses with pointer and occupancy tracking.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr_en        - write wr_data at the write pointer (ignored when full)
//   rd_en        - retire the head entry (ignored when empty)
//   wr_data      - address to store
//   rd_data      - head entry as it stands after this cycle's read/write
//   count        - occupied entries
//   full, empty  - occupancy flags
module compl_fifo_mem
  import ctrl_pkg::*;
#(
  parameter int ADDRW = ADDRW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [ADDRW-1:0]          wr_data,
  output logic [ADDRW-1:0]          rd_data,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTRW = clog2(DEPTH);
  localparam int CNTW = clog2(DEPTH + 1);

  logic [ADDRW-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wr_ptr;
  logic [PTRW-1:0]  r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_wr;
  logic             w_rd;
  logic [PTRW-1:0]  w_rd_ptr_nxt;

  assign full         = (r_count == CNTW'(DEPTH));
  assign empty        = (r_count == CNTW'(0));
  assign count        = r_count;
  assign w_wr         = wr_en && !full;
  assign w_rd         = rd_en && !empty;
  // DEPTH is a power of two, so pointers wrap naturally.
  assign w_rd_ptr_nxt = w_rd ? (r_rd_ptr + PTRW'(1)) : r_rd_ptr;

  // Look-ahead head: lets the FSM latch the next entry on the same edge that
  // retires the current one. A write landing in the (empty) next-head slot is forwarded.
  always_comb begin
    if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
      rd_data = wr_data;
    end else begin
      rd_data = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= ADDRW'(0);
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous write and read keep count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PTRW'(0);
      r_rd_ptr <= PTRW'(0);
      r_count  <= CNTW'(0);
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTRW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/compl_queue.sv
// compl_queue
// Completion queue feeding the SPI MISO serializer. Buffers completed-request
// addresses, offers the head over a valid/ready handshake, and tracks it until
// the serializer finishes the frame.
// Build option: define COMPL_REPLAY_EN to re-offer an entry whose frame was
// aborted (err_in at completion), dropping it after MAX_RETRY aborts.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push_valid    - completion entry offered; push_addr carries its address
//   push_ready    - queue not full (combinational)
//   valid_out     - head offered to serializer (registered)
//   addr_out      - head address, stable from offer until retire (registered)
//   ready_in      - serializer ready; falling = accept, rising = frame done
//   err_in        - serializer abort flag, sampled only with the ready_in rise
//   count         - occupied entries
//   drop_pulse    - one-cycle pulse when an entry is discarded after MAX_RETRY aborts
module compl_queue
  import ctrl_pkg::*;
#(
  parameter int ADDRW     = ADDRW_DEFAULT,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_valid,
  input  logic [ADDRW-1:0]          push_addr,
  output logic                      push_ready,
  output logic                      valid_out,
  output logic [ADDRW-1:0]          addr_out,
  input  logic                      ready_in,
  input  logic                      err_in,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      drop_pulse
);

  localparam int CNTW = clog2(DEPTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready_in_q;
  logic             r_valid_out;
  logic [ADDRW-1:0] r_addr_out;
  logic [ADDRW-1:0] w_rd_data;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_complete;
  logic             w_retire;
  logic             w_replay;
  logic             w_more;

  assign push_ready = !w_full;
  assign valid_out  = r_valid_out;
  assign addr_out   = r_addr_out;
  assign w_push     = push_valid && push_ready;
  assign w_accept   = (r_state == ST_OFFER) && r_ready_in_q && !ready_in;
  assign w_complete = (r_state == ST_INFLIGHT) && !r_ready_in_q && ready_in;
  // Queue still holds something after this cycle's push/retire.
  assign w_more     = w_push || (count > CNTW'(w_retire));

`ifdef COMPL_REPLAY_EN
  localparam int RTYW = clog2(MAX_RETRY + 1);

  logic [RTYW-1:0] r_retry_cnt;
  logic            r_drop_pulse;
  logic            w_abort;
  logic            w_drop;

  assign w_abort    = w_complete && err_in;
  assign w_drop     = w_abort && (r_retry_cnt == RTYW'(MAX_RETRY - 1));
  assign w_replay   = w_abort && !w_drop;
  assign w_retire   = w_complete && !w_replay;
  assign drop_pulse = r_drop_pulse;

  // Abort counter for the head entry and the drop notification pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry_cnt  <= RTYW'(0);
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= w_drop;
      if (w_retire) begin
        r_retry_cnt <= RTYW'(0);
      end else if (w_abort) begin
        r_retry_cnt <= r_retry_cnt + RTYW'(1);
      end else begin
        r_retry_cnt <= r_retry_cnt;
      end
    end
  end
`else
  logic w_unused;

  // Without replay the entry leaves the queue once the serializer accepts it.
  assign w_retire   = w_accept;
  assign w_replay   = 1'b0;
  assign drop_pulse = 1'b0;
  assign w_unused   = err_in | (MAX_RETRY < 32'sd1);
`endif

  compl_fifo_mem #(
    .ADDRW (ADDRW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_push),
    .rd_en   (w_retire),
    .wr_data (push_addr),
    .rd_data (w_rd_data),
    .count   (count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Handshake FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_OFFER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (w_accept) begin
          w_state_nxt = ST_INFLIGHT;
        end else begin
          w_state_nxt = ST_OFFER;
        end
      end
      ST_INFLIGHT: begin
        if (w_complete) begin
          if (w_replay || w_more) begin
            w_state_nxt = ST_OFFER;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_INFLIGHT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, registered handshake outputs and ready_in edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready_in_q <= 1'b1;
      r_valid_out  <= 1'b0;
      r_addr_out   <= ADDRW'(0);
    end else begin
      r_state      <= w_state_nxt;
      r_ready_in_q <= ready_in;
      r_valid_out  <= (w_state_nxt == ST_OFFER);
      // Address is captured only on entry to OFFER and held until the next offer.
      if ((w_state_nxt == ST_OFFER) && (r_state != ST_OFFER)) begin
        r_addr_out <= w_rd_data;
      end else begin
        r_addr_out <= r_addr_out;
      end
    end
  end

endmodule

// File: tb/tb_compl_queue.sv
// tb_compl_queue
// Self-checking bench for compl_queue (DEPTH=4, MAX_RETRY=3). A scoreboard queue
// holds the addresses the queue should contain; entries are popped when the DUT
// should retire them and compared against addr_out when offered.
// Expectations follow COMPL_REPLAY_EN when the bench is built with that macro.
module tb_compl_queue;

  localparam int ADDRW     = 24;
  localparam int DEPTH     = 4;
  localparam int MAX_RETRY = 3;
  localparam int CNTW      = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             push_valid;
  logic [ADDRW-1:0] push_addr;
  logic             push_ready;
  logic             valid_out;
  logic [ADDRW-1:0] addr_out;
  logic             ready_in;
  logic             err_in;
  logic [CNTW-1:0]  count;
  logic             drop_pulse;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [ADDRW-1:0] sb[$];
  int               m_retry  = 0;

  compl_queue #(
    .ADDRW     (ADDRW),
    .DEPTH     (DEPTH),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_addr  (push_addr),
    .push_ready (push_ready),
    .valid_out  (valid_out),
    .addr_out   (addr_out),
    .ready_in   (ready_in),
    .err_in     (err_in),
    .count      (count),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push_valid = 1'b0; push_addr = '0; ready_in = 1'b1; err_in = 1'b0;
    #3;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_checks++; if (addr_out !== 24'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 000000", addr_out); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop_pulse); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  // Cycle-accurate single transfer: push at cycle 0, accept at 5, complete at 30.
  task automatic test_single_timing();
    logic            exp_v;
    logic [CNTW-1:0] exp_cnt;
    for (int c = 0; c <= 33; c++) begin
      push_valid = (c == 0);
      push_addr  = 24'hABCDEF;
      ready_in   = !((c >= 5) && (c < 30));
      exp_v      = (c >= 2) && (c <= 5);
`ifdef COMPL_REPLAY_EN
      exp_cnt    = ((c >= 1) && (c <= 30)) ? 3'd1 : 3'd0;
`else
      exp_cnt    = ((c >= 1) && (c <= 5)) ? 3'd1 : 3'd0;
`endif
      @(negedge clk);
      n_checks++; if (valid_out !== exp_v) begin n_fail++; $display("FAIL single_valid c=%0d: got %b want %b", c, valid_out, exp_v); end
      n_checks++; if (count !== exp_cnt) begin n_fail++; $display("FAIL single_count c=%0d: got %0d want %0d", c, count, exp_cnt); end
      if (c >= 2) begin
        n_checks++; if (addr_out !== 24'hABCDEF) begin n_fail++; $display("FAIL single_addr c=%0d: got %h want abcdef", c, addr_out); end
      end
      @(posedge clk); #1;
    end
    push_valid = 1'b0;
  endtask

  task automatic do_push(input logic [ADDRW-1:0] a);
    logic exp_acc;
    exp_acc    = (sb.size() != DEPTH);
    push_valid = 1'b1;
    push_addr  = a;
    n_checks++; if (push_ready !== exp_acc) begin n_fail++; $display("FAIL push_ready: got %b want %b", push_ready, exp_acc); end
    if (exp_acc) sb.push_back(a);
    tick();
    push_valid = 1'b0;
    n_checks++; if (count !== CNTW'(sb.size())) begin n_fail++; $display("FAIL push_count: got %0d want %0d", count, sb.size()); end
  endtask

  // Serializer model: accept the offered head, hold the frame, then complete
  // with the given err flag; optionally push in the cycle the head retires.
  task automatic xfer(input logic err, input logic push, input logic [ADDRW-1:0] pa);
    int               guard;
    logic             exp_acc;
    logic             exp_drop;
    logic [ADDRW-1:0] exp_a;
    guard    = 0;
    exp_acc  = 1'b0;
    exp_drop = 1'b0;
    while ((valid_out !== 1'b1) && (guard < 20)) begin
      tick();
      guard++;
    end
    n_checks++;
    if (valid_out !== 1'b1) begin
      n_fail++; $display("FAIL offer_timeout: valid_out=%b want 1", valid_out);
      return;
    end
    exp_a = (sb.size() != 0) ? sb[0] : 'x;
    n_checks++; if (addr_out !== exp_a) begin n_fail++; $display("FAIL offer_addr: got %h want %h", addr_out, exp_a); end
    ready_in = 1'b0;
`ifndef COMPL_REPLAY_EN
    if (push) begin
      exp_acc = (sb.size() != DEPTH);
      push_valid = 1'b1; push_addr = pa;
      n_checks++; if (push_ready !== exp_acc) begin n_fail++; $display("FAIL retire_push_ready: got %b want %b", push_ready, exp_acc); end
    end
    void'(sb.pop_front());
    if (exp_acc) sb.push_back(pa);
`endif
    tick();
    push_valid = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL accept_valid: got %b want 0", valid_out); end
    n_checks++; if (count !== CNTW'(sb.size())) begin n_fail++; $display("FAIL accept_count: got %0d want %0d", count, sb.size()); end
    repeat (3) tick();
    ready_in = 1'b1;
    err_in   = err;
`ifdef COMPL_REPLAY_EN
    if (push) begin
      exp_acc = (sb.size() != DEPTH);
      push_valid = 1'b1; push_addr = pa;
      n_checks++; if (push_ready !== exp_acc) begin n_fail++; $display("FAIL retire_push_ready: got %b want %b", push_ready, exp_acc); end
    end
    if (err) begin
      m_retry++;
      if (m_retry == MAX_RETRY) begin
        exp_drop = 1'b1; m_retry = 0; void'(sb.pop_front());
      end
    end else begin
      m_retry = 0; void'(sb.pop_front());
    end
    if (exp_acc) sb.push_back(pa);
`endif
    tick();
    err_in = 1'b0; push_valid = 1'b0;
    n_checks++; if (drop_pulse !== exp_drop) begin n_fail++; $display("FAIL done_drop: got %b want %b", drop_pulse, exp_drop); end
    n_checks++; if (count !== CNTW'(sb.size())) begin n_fail++; $display("FAIL done_count: got %0d want %0d", count, sb.size()); end
    n_checks++; if (valid_out !== (sb.size() != 0)) begin n_fail++; $display("FAIL done_reoffer: got %b want %b", valid_out, (sb.size() != 0)); end
    if (sb.size() != 0) begin
      exp_a = sb[0];
      n_checks++; if (addr_out !== exp_a) begin n_fail++; $display("FAIL done_addr: got %h want %h", addr_out, exp_a); end
    end
    tick();
    n_checks++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_width: got %b want 0", drop_pulse); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 5; i++) do_push(ADDRW'(i));
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    repeat (4) xfer(1'b0, 1'b0, '0);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_push_on_retire();
    for (int i = 0; i < 4; i++) do_push(24'h000010 + ADDRW'(i));
    xfer(1'b0, 1'b1, 24'h000099);
    xfer(1'b0, 1'b1, 24'h000014);
    repeat (3) xfer(1'b0, 1'b0, '0);
  endtask

  task automatic test_err_abort();
    do_push(24'h5A5A5A);
    do_push(24'h6B6B6B);
    xfer(1'b1, 1'b0, '0);
    xfer(1'b0, 1'b0, '0);
`ifdef COMPL_REPLAY_EN
    xfer(1'b0, 1'b0, '0);
`endif
  endtask

  task automatic test_drop();
    do_push(24'h111111);
    do_push(24'h222222);
`ifdef COMPL_REPLAY_EN
    repeat (MAX_RETRY) xfer(1'b1, 1'b0, '0);
    xfer(1'b0, 1'b0, '0);
`else
    xfer(1'b1, 1'b0, '0);
    xfer(1'b1, 1'b0, '0);
`endif
  endtask

  task automatic test_reset_inflight();
    int guard;
    guard = 0;
    do_push(24'h777777);
    while ((valid_out !== 1'b1) && (guard < 20)) begin
      tick();
      guard++;
    end
    ready_in = 1'b0;
`ifndef COMPL_REPLAY_EN
    void'(sb.pop_front());
`endif
    tick();
    n_checks++; if (count !== CNTW'(sb.size())) begin n_fail++; $display("FAIL inflight_count: got %0d want %0d", count, sb.size()); end
    #2;
    rst_n = 1'b0; ready_in = 1'b1;
    sb.delete(); m_retry = 0;
    #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_valid: got %b want 0", valid_out); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_inflight_count: got %0d want 0", count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b want 0", valid_out); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL post_rst_count: got %0d want 0", count); end
    do_push(24'h0A0B0C);
    xfer(1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_single_timing();
    test_fill_wrap();
    test_push_on_retire();
    test_err_abort();
    test_drop();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
